rot_issue_stage: RTL

ROT_ISSUE_STAGE -- requirements
Module: rot_issue_stage

---
 rtl/rot_issue_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rot_issue_stage.sv
// Issue stage for an external combinational right-rotate unit: requests queue in a
// 2-entry FIFO, are driven one at a time, and the captured result is held until accepted.
module rot_issue_stage #(
    parameter int ADDRESS_BITS = 3,
    parameter int WIDTH        = 2 ** ADDRESS_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] in_amt,
    input  logic [WIDTH-1:0]        in_num,
    output logic [ADDRESS_BITS-1:0] rot_amt,
    output logic [WIDTH-1:0]        rot_num,
    input  logic [WIDTH-1:0]        rot_shifted,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    busy,
    output logic [15:0]             op_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESULT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] fifo_amt_q [2];
    logic [WIDTH-1:0]        fifo_num_q [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              count_q, count_d;
    logic [ADDRESS_BITS-1:0] rot_amt_q, rot_amt_d;
    logic [WIDTH-1:0]        rot_num_q, rot_num_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic [15:0]             op_count_q, op_count_d;
    logic                    push;
    logic                    pop;

    assign in_ready = !reset && (count_q < 2'd2);
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        rot_amt_d   = rot_amt_q;
        rot_num_d   = rot_num_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        op_count_d  = op_count_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != 2'd0) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                out_data_d  = rot_shifted;
                out_valid_d = 1'b1;
                state_d     = ST_RESULT;
            end
            ST_RESULT: begin
                if (out_ready) begin
                    op_count_d  = op_count_q + 16'd1;
                    out_valid_d = 1'b0;
                    // Back-to-back: the next request is driven on the same edge the result retires.
                    if (count_q != 2'd0) begin
                        pop     = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            rot_amt_d = fifo_amt_q[rd_ptr_q];
            rot_num_d = fifo_num_q[rd_ptr_q];
        end

        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= '0;
            rot_amt_q   <= '0;
            rot_num_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rot_amt_q   <= rot_amt_d;
            rot_num_q   <= rot_num_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            op_count_q  <= op_count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_amt_q[wr_ptr_q] <= in_amt;
            fifo_num_q[wr_ptr_q] <= in_num;
        end
    end

    assign rot_amt   = rot_amt_q;
    assign rot_num   = rot_num_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != ST_IDLE) || (count_q != 2'd0);

endmodule
